// File: rtl/scc_channel_sequencer.sv
// SCC channel sequencer: on each sound tick, visits every channel in order.
// For each channel it updates the period counter and the wave pointer, fetches the wave sample
// over a req/ack handshake, and emits one sample to the mixer.
module scc_channel_sequencer #(
   parameter int unsigned CHANNELS   = 5,
   parameter int unsigned MIN_PERIOD = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic [CHANNELS-1:0] key_on,
   input  logic [CHANNELS-1:0] period_wr,
   output logic [2:0]          active,
   input  logic [11:0]         period_in,
   output logic                wave_req,
   output logic [7:0]          wave_addr,
   input  logic                wave_ack,
   input  logic [7:0]          wave_data,
   output logic                sample_valid,
   output logic [2:0]          sample_ch,
   output logic [7:0]          sample,
   output logic                frame_end,
   output logic                overrun
);

   localparam logic [2:0] LastCh = 3'(CHANNELS - 1);

   typedef enum logic [2:0] {StIdle, StSel, StCnt, StReq, StOut} state_e;

   state_e              state_q, state_d;
   logic [2:0]          ch_q, ch_d;
   logic [11:0]         count_q [CHANNELS];
   logic [4:0]          ptr_q [CHANNELS];
   logic [CHANNELS-1:0] pending_q;
   logic [7:0]          wave_addr_q;
   logic [7:0]          sample_q;
   logic [2:0]          sample_ch_q;
   logic                overrun_q;

   logic [11:0]         cur_count, count_d;
   logic [4:0]          cur_ptr, ptr_d;
   logic                key_off;
   logic [CHANNELS-1:0] pending_clr;

   // Next state and channel index of the visit sequence.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      unique case (state_q)
         StIdle: begin
            if (tick) begin
               state_d = StSel;
               ch_d    = 3'd0;
            end
         end
         StSel:   state_d = StCnt;
         StCnt:   state_d = key_off ? StOut : StReq;
         StReq:   if (wave_ack) state_d = StOut;
         StOut: begin
            if (ch_q == LastCh) begin
               state_d = StIdle;
            end else begin
               ch_d    = ch_q + 3'd1;
               state_d = StSel;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Counter/pointer update for the channel being visited; first matching rule wins.
   always_comb begin
      cur_count   = count_q[ch_q];
      cur_ptr     = ptr_q[ch_q];
      key_off     = !key_on[ch_q];
      count_d     = cur_count;
      ptr_d       = cur_ptr;
      pending_clr = '0;
      if (key_off) begin
         count_d = period_in;
         ptr_d   = 5'd0;
         pending_clr[ch_q] = (state_q == StCnt);
      end else if (pending_q[ch_q]) begin
         count_d = period_in;
         pending_clr[ch_q] = (state_q == StCnt);
      end else if (period_in < 12'(MIN_PERIOD)) begin
         count_d = period_in;
      end else if (cur_count == 12'd0) begin
         count_d = period_in;
         ptr_d   = cur_ptr + 5'd1;
      end else begin
         count_d = cur_count - 12'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ch_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
      end
   end

   // Per-channel counters, pointers and pending flags; a new write strobe beats the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            count_q[i] <= 12'd0;
            ptr_q[i]   <= 5'd0;
         end
         pending_q <= '0;
      end else begin
         if (state_q == StCnt) begin
            count_q[ch_q] <= count_d;
            ptr_q[ch_q]   <= ptr_d;
         end
         pending_q <= (pending_q & ~pending_clr) | period_wr;
      end
   end

   // Held outputs: wave address, sample, sample channel, and the overrun pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         wave_addr_q <= 8'd0;
         sample_q    <= 8'd0;
         sample_ch_q <= 3'd0;
         overrun_q   <= 1'b0;
      end else begin
         overrun_q <= tick && (state_q != StIdle);
         if (state_q == StCnt) begin
            if (key_off) begin
               sample_q    <= 8'd0;
               sample_ch_q <= ch_q;
            end else begin
               wave_addr_q <= {ch_q, ptr_d};
            end
         end
         if (state_q == StReq && wave_ack) begin
            sample_q    <= wave_data;
            sample_ch_q <= ch_q;
         end
      end
   end

   // Outputs decoded from state.
   always_comb begin
      active       = (state_q == StIdle) ? 3'd7 : ch_q;
      wave_req     = (state_q == StReq);
      wave_addr    = wave_addr_q;
      sample_valid = (state_q == StOut);
      sample_ch    = sample_ch_q;
      sample       = sample_q;
      frame_end    = (state_q == StOut) && (ch_q == LastCh);
      overrun      = overrun_q;
   end

endmodule

// File: tb/tb_scc_channel_sequencer.sv
// Scoreboard bench for scc_channel_sequencer: a frame-level reference model pushes expected
// wave addresses and samples on each tick; a negedge monitor pops and compares.
module tb_scc_channel_sequencer;

   localparam int NCH  = 5;
   localparam int MINP = 9;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic [4:0] key_on = '0;
   logic [4:0] period_wr = '0;
   logic [2:0] active;
   logic [11:0] period_in;
   logic       wave_req;
   logic [7:0] wave_addr;
   logic       wave_ack = 1'b0;
   logic [7:0] wave_data = '0;
   logic       sample_valid;
   logic [2:0] sample_ch;
   logic [7:0] sample;
   logic       frame_end;
   logic       overrun;

   scc_channel_sequencer #(.CHANNELS(NCH), .MIN_PERIOD(MINP)) dut (
      .clk(clk), .reset(reset), .tick(tick), .key_on(key_on), .period_wr(period_wr),
      .active(active), .period_in(period_in), .wave_req(wave_req), .wave_addr(wave_addr),
      .wave_ack(wave_ack), .wave_data(wave_data), .sample_valid(sample_valid),
      .sample_ch(sample_ch), .sample(sample), .frame_end(frame_end), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [2:0] ch;
      logic [7:0] data;
      logic       fe;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] addr_q[$];
   int         out_cyc[$];

   logic [7:0]  mem [256];
   logic [11:0] periods [NCH];
   logic [11:0] m_cnt [NCH];
   logic [4:0]  m_ptr [NCH];
   logic [NCH-1:0] m_pend;

   int checks = 0;
   int errors = 0;
   bit busy = 0;
   int tick_cyc = 0;
   int ovr_cyc = -1;
   int ovr_seen = 0;
   int ack_delay = 0;
   int wcnt = 0;
   int ack_cyc = 0;
   int req_len = 0;
   int last_req_len = 0;
   logic       prev_req = 1'b0;
   logic [7:0] held_addr = '0;
   exp_t       e_s;
   logic [7:0] e_a;

   // Register-file selector model.
   always_comb begin
      period_in = 12'd0;
      if (active < 3'(NCH)) period_in = periods[active];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 12'd0;
         m_ptr[c] = 5'd0;
      end
      m_pend = '0;
   endtask

   // Whole-frame expectation computed from the channel rules.
   task automatic model_frame();
      exp_t e;
      logic [7:0] a;
      for (int c = 0; c < NCH; c++) begin
         e.ch = 3'(c);
         e.fe = (c == NCH - 1);
         if (!key_on[c]) begin
            m_ptr[c]  = 5'd0;
            m_cnt[c]  = periods[c];
            m_pend[c] = 1'b0;
            e.data    = 8'd0;
         end else begin
            if (m_pend[c]) begin
               m_cnt[c]  = periods[c];
               m_pend[c] = 1'b0;
            end else if (periods[c] < MINP) begin
               m_cnt[c] = periods[c];
            end else if (m_cnt[c] == 0) begin
               m_cnt[c] = periods[c];
               m_ptr[c] = 5'((int'(m_ptr[c]) + 1) % 32);
            end else begin
               m_cnt[c] = m_cnt[c] - 12'd1;
            end
            a = 8'(c * 32 + int'(m_ptr[c]));
            addr_q.push_back(a);
            e.data = mem[a];
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic do_tick();
      if (!busy) begin
         model_frame();
         busy     = 1;
         tick_cyc = cyc;
         out_cyc.delete();
      end else begin
         ovr_cyc = cyc + 1;
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin
         step();
         n++;
      end
      if (busy) begin
         chk("frame completion timeout", 0, 1);
         busy = 0;
         exp_q.delete();
         addr_q.delete();
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!wave_req && n < 200) begin
         step();
         n++;
      end
      if (!wave_req) chk("wave_req timeout", 0, 1);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      exp_q.delete();
      addr_q.delete();
      busy    = 0;
      ovr_cyc = -1;
      model_reset();
      step();
      reset = 1'b0;
   endtask

   // Wave RAM responder: acks after ack_delay wait cycles with mem[wave_addr].
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (wave_req && !wave_ack) begin
            if (wcnt >= ack_delay) begin
               wave_ack  = 1'b1;
               wave_data = mem[wave_addr];
               ack_cyc   = cyc;
               wcnt      = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wave_ack = 1'b0;
            wcnt     = 0;
         end
      end
   end

   // Monitor: compares DUT outputs with the scoreboard queues.
   always @(negedge clk) begin
      if (reset) begin
         prev_req = 1'b0;
      end else begin
         if (overrun) ovr_seen++;
         if (overrun || cyc == ovr_cyc) chk("overrun", int'(overrun), int'(cyc == ovr_cyc));
         if (wave_req) begin
            if (!prev_req) begin
               if (addr_q.size() == 0) begin
                  chk("unexpected wave_req", 1, 0);
               end else begin
                  e_a = addr_q.pop_front();
                  chk("wave_addr", int'(wave_addr), int'(e_a));
               end
               held_addr = wave_addr;
               req_len   = 1;
            end else begin
               chk("wave_addr stable", int'(wave_addr), int'(held_addr));
               req_len++;
            end
         end else if (prev_req) begin
            last_req_len = req_len;
         end
         prev_req = wave_req;
         if (frame_end && !sample_valid) chk("frame_end without sample_valid", 1, 0);
         if (sample_valid) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               chk("unexpected sample_valid", 1, 0);
            end else begin
               e_s = exp_q.pop_front();
               chk("sample_ch", int'(sample_ch), int'(e_s.ch));
               chk("sample", int'(sample), int'(e_s.data));
               chk("frame_end", int'(frame_end), int'(e_s.fe));
               if (e_s.fe) busy = 0;
            end
         end
      end
   end

   initial begin
      int ovr0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int c = 0; c < NCH; c++) periods[c] = 12'd9;
      model_reset();

      // Reset state
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      chk("reset active", int'(active), 7);
      chk("reset wave_req", int'(wave_req), 0);
      chk("reset wave_addr", int'(wave_addr), 0);
      chk("reset sample_valid", int'(sample_valid), 0);
      chk("reset sample_ch", int'(sample_ch), 0);
      chk("reset sample", int'(sample), 0);
      chk("reset frame_end", int'(frame_end), 0);
      chk("reset overrun", int'(overrun), 0);
      step();

      // All keyed off: five OUT pulses three cycles apart
      key_on = 5'b00000;
      do_tick();
      wait_idle();
      chk("keyoff out count", out_cyc.size(), 5);
      for (int i = 0; i < out_cyc.size(); i++)
         chk("keyoff out cycle", out_cyc[i], tick_cyc + 3 * (i + 1));
      step();
      chk("idle active", int'(active), 7);

      // Period 9 on ch0: pointer advances every 10 ticks, wraps after 31
      apply_reset();
      key_on     = 5'b00001;
      periods[0] = 12'd9;
      ack_delay  = 0;
      for (int t = 1; t <= 315; t++) begin
         do_tick();
         wait_idle();
         if (t == 1) chk("first sample latency", out_cyc[0], tick_cyc + 4);
         if (t <= 10) chk("addr ticks 1-10", int'(held_addr), 1);
         if (t == 11) chk("addr tick 11", int'(held_addr), 2);
         if (t == 310) chk("addr before wrap", int'(held_addr), 31);
         if (t == 311) chk("addr after wrap", int'(held_addr), 0);
         step();
      end

      // Delayed ack with an overrun tick during the wait
      ack_delay = 3;
      ovr0 = ovr_seen;
      do_tick();
      wait_req();
      step();
      do_tick();
      wait_idle();
      chk("req length", last_req_len, 4);
      chk("out after ack", out_cyc[0], ack_cyc + 1);
      chk("overrun pulses", ovr_seen - ovr0, 1);
      ack_delay = 0;
      step();

      // Pending reload: idle strobe, then strobe coinciding with ch2's CNT cycle
      key_on     = 5'b00100;
      periods[2] = 12'd20;
      repeat (3) begin
         do_tick();
         wait_idle();
         step();
      end
      period_wr = 5'b00100;
      m_pend[2] = 1'b1;
      step();
      period_wr = '0;
      do_tick();
      wait_idle();
      step();
      do_tick();
      repeat (7) step();
      chk("ch2 cnt active", int'(active), 2);
      chk("ch2 cnt no req", int'(wave_req), 0);
      period_wr = 5'b00100;
      step();
      period_wr = '0;
      m_pend[2] = 1'b1;
      wait_idle();
      repeat (25) begin
         do_tick();
         wait_idle();
         step();
      end

      // Randomized frames
      for (int f = 0; f < 150; f++) begin
         key_on = 5'($urandom);
         for (int c = 0; c < NCH; c++)
            periods[c] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 12))
                                                     : 12'($urandom_range(0, 40));
         ack_delay = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) begin
            period_wr = 5'($urandom);
            m_pend    = m_pend | period_wr;
            step();
            period_wr = '0;
         end
         do_tick();
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 12)) step();
            do_tick();
         end
         wait_idle();
         repeat ($urandom_range(0, 2)) step();
      end

      // Reset during a pending wave request
      key_on     = 5'b00001;
      periods[0] = 12'd9;
      ack_delay  = 20;
      do_tick();
      wait_req();
      step();
      apply_reset();
      chk("post-reset wave_req", int'(wave_req), 0);
      chk("post-reset active", int'(active), 7);
      chk("post-reset sample_valid", int'(sample_valid), 0);
      ack_delay = 0;
      step();
      do_tick();
      wait_idle();
      chk("restart addr", int'(held_addr), 1);
      step();

      chk("leftover samples", exp_q.size(), 0);
      chk("leftover addrs", addr_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
